// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 frame-memory feeder.
package hub75_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DROP
    } state_t;

    localparam int PIXEL_BITS = 8;

    typedef struct packed {
        logic [PIXEL_BITS-1:0] r;
        logic [PIXEL_BITS-1:0] g;
        logic [PIXEL_BITS-1:0] b;
    } pixel_t;

    function automatic int frame_lines(input int n, input int height);
        return n * height;
    endfunction

    function automatic int frame_depth(input int n, input int height, input int width);
        return n * height * width;
    endfunction

    // Counter width that stays legal (>= 1 bit) for degenerate sizes of 1.
    function automatic int bits_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/hub75_stream_writer.sv
// AXI4-Stream video to HUB75 frame-memory writer: enforces line/frame framing,
// writes each accepted pixel at its linear address one cycle later.
module hub75_stream_writer
    import hub75_pkg::*;
#(
    parameter int N         = 2,
    parameter int WIDTH     = 64,
    parameter int HEIGHT    = 32,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = frame_depth(N, HEIGHT, WIDTH),
    parameter int ADDR_BITS = bits_for(DEPTH)
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   enable,
    input  logic                   s_axi4s_tuser,
    input  logic                   s_axi4s_tlast,
    input  logic [3*DATA_BITS-1:0] s_axi4s_tdata,
    input  logic                   s_axi4s_tvalid,
    output logic                   s_axi4s_tready,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic [DATA_BITS-1:0]   mem_r,
    output logic [DATA_BITS-1:0]   mem_g,
    output logic [DATA_BITS-1:0]   mem_b,
    output logic                   frame_done,
    output logic                   err_short,
    output logic                   err_long,
    output logic                   err_sof
);

    localparam int LINES = frame_lines(N, HEIGHT);
    localparam int XB    = bits_for(WIDTH);
    localparam int YB    = bits_for(LINES);

    localparam logic [XB-1:0]        X_LAST     = XB'(WIDTH - 1);
    localparam logic [YB-1:0]        Y_LAST     = YB'(LINES - 1);
    localparam logic [ADDR_BITS-1:0] LINE_STEP  = ADDR_BITS'(WIDTH);

    typedef struct packed {
        logic [DATA_BITS-1:0] r;
        logic [DATA_BITS-1:0] g;
        logic [DATA_BITS-1:0] b;
    } px_t;

    state_t               state_q, state_d;
    logic [XB-1:0]        x_q, x_d;
    logic [YB-1:0]        y_q, y_d;
    logic [ADDR_BITS-1:0] line_base_q, line_base_d;
    logic                 tready_q, tready_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    px_t                  mem_pix_q, mem_pix_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_short_q, err_short_d;
    logic                 err_long_q, err_long_d;
    logic                 err_sof_q, err_sof_d;

    logic                 accept;
    logic                 write_beat;
    logic                 end_line;
    logic [XB-1:0]        cur_x;
    logic [YB-1:0]        cur_y;
    logic [ADDR_BITS-1:0] cur_base;

    assign accept = s_axi4s_tvalid & tready_q;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        line_base_d  = line_base_q;
        tready_d     = 1'b1;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_pix_d    = mem_pix_q;
        frame_done_d = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        err_sof_d    = 1'b0;
        write_beat   = 1'b0;
        end_line     = 1'b0;
        cur_x        = x_q;
        cur_y        = y_q;
        cur_base     = line_base_q;

        // SOF wins over tlast and overflow: the beat is re-evaluated as pixel (0,0).
        if (accept) begin
            if (s_axi4s_tuser) begin
                cur_x     = '0;
                cur_y     = '0;
                cur_base  = '0;
                err_sof_d = (state_q != WAIT_SOF);
                if (enable) begin
                    write_beat = 1'b1;
                end else begin
                    state_d     = WAIT_SOF;
                    x_d         = '0;
                    y_d         = '0;
                    line_base_d = '0;
                end
            end else if (state_q == ACTIVE) begin
                write_beat = 1'b1;
            end else if (state_q == DROP && s_axi4s_tlast) begin
                end_line = 1'b1;
            end
        end

        if (write_beat) begin
            mem_we_d   = 1'b1;
            mem_addr_d = cur_base + ADDR_BITS'(cur_x);
            mem_pix_d  = px_t'(s_axi4s_tdata);
            state_d    = ACTIVE;
            x_d        = cur_x;
            y_d        = cur_y;
            line_base_d = cur_base;
            if (s_axi4s_tlast) begin
                err_short_d = (cur_x != X_LAST);
                end_line    = 1'b1;
            end else if (cur_x == X_LAST) begin
                err_long_d = 1'b1;
                state_d    = DROP;
            end else begin
                x_d = cur_x + 1'b1;
            end
        end

        if (end_line) begin
            x_d = '0;
            if (cur_y == Y_LAST) begin
                frame_done_d = 1'b1;
                state_d      = WAIT_SOF;
                y_d          = '0;
                line_base_d  = '0;
            end else begin
                state_d     = ACTIVE;
                y_d         = cur_y + 1'b1;
                line_base_d = cur_base + LINE_STEP;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            line_base_q  <= '0;
            tready_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_pix_q    <= '0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_base_q  <= line_base_d;
            tready_q     <= tready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_pix_q    <= mem_pix_d;
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign s_axi4s_tready = tready_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_r          = mem_pix_q.r;
    assign mem_g          = mem_pix_q.g;
    assign mem_b          = mem_pix_q.b;
    assign frame_done     = frame_done_q;
    assign err_short      = err_short_q;
    assign err_long       = err_long_q;
    assign err_sof        = err_sof_q;

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Scoreboard bench for hub75_stream_writer on a 4x(2*2) frame.
module tb_hub75_stream_writer;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int DB = 8;
    localparam int AB = 4;
    localparam int LINES = N * H;

    logic              reset;
    logic              clk;
    logic              enable;
    logic              tuser;
    logic              tlast;
    logic [3*DB-1:0]   tdata;
    logic              tvalid;
    logic              tready;
    logic              mem_we;
    logic [AB-1:0]     mem_addr;
    logic [DB-1:0]     mem_r;
    logic [DB-1:0]     mem_g;
    logic [DB-1:0]     mem_b;
    logic              frame_done;
    logic              err_short;
    logic              err_long;
    logic              err_sof;

    hub75_stream_writer #(
        .N(N), .WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)
    ) dut (
        .reset          (reset),
        .clk            (clk),
        .enable         (enable),
        .s_axi4s_tuser  (tuser),
        .s_axi4s_tlast  (tlast),
        .s_axi4s_tdata  (tdata),
        .s_axi4s_tvalid (tvalid),
        .s_axi4s_tready (tready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_r          (mem_r),
        .mem_g          (mem_g),
        .mem_b          (mem_b),
        .frame_done     (frame_done),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_sof        (err_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed expectation: {we, addr, rgb, frame_done, err_short, err_long, err_sof}
    typedef logic [1+AB+3*DB+4-1:0] obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Every cycle with a write or a pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        obs_t got;
        obs_t exp;
        if (mem_we === 1'b1 || frame_done === 1'b1 || err_short === 1'b1 ||
            err_long === 1'b1 || err_sof === 1'b1) begin
            got = {mem_we, mem_addr, mem_r, mem_g, mem_b, frame_done, err_short, err_long, err_sof};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got we=%0b addr=%0d rgb=%06h fd/es/el/eo=%04b, expected nothing",
                         mem_we, mem_addr, {mem_r, mem_g, mem_b}, got[3:0]);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL output: got we=%0b addr=%0d rgb=%06h fd/es/el/eo=%04b, expected we=%0b addr=%0d rgb=%06h fd/es/el/eo=%04b",
                             got[1+AB+3*DB+3], got[AB+3*DB+3:3*DB+4], got[3*DB+3:4], got[3:0],
                             exp[1+AB+3*DB+3], exp[AB+3*DB+3:3*DB+4], exp[3*DB+3:4], exp[3:0]);
                end
            end
        end
    end

    // Drive one beat for one clock; push its expected output if it should produce one.
    task automatic beat(input logic u, input logic l, input logic [3*DB-1:0] d,
                        input logic ewe, input logic [AB-1:0] eaddr,
                        input logic efd, input logic es, input logic el, input logic eo);
        if (ewe || efd || es || el || eo)
            sb.push_back({ewe, eaddr, (ewe ? d : {3*DB{1'b0}}), efd, es, el, eo});
        tuser  = u;
        tlast  = l;
        tdata  = d;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d outputs missing, expected 0", name, sb.size());
        end
        sb.delete();
    endtask

    function automatic logic [3*DB-1:0] pix(input int seed, input int idx);
        return {8'(seed), 8'(idx), 8'(seed ^ (idx * 7))};
    endfunction

    // Normal line: pixels x0..W-1 of line y; SOF on (0,0) when first_sof.
    task automatic clean_line(input int seed, input int y, input int x0, input logic first_sof);
        for (int x = x0; x < W; x++) begin
            beat(first_sof && x == x0 && y == 0, x == W - 1, pix(seed, y * W + x),
                 1'b1, AB'(y * W + x), (x == W - 1) && (y == LINES - 1), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clean_frame(input int seed);
        for (int y = 0; y < LINES; y++) clean_line(seed, y, 0, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tready, mem_we, mem_addr, mem_r, mem_g, mem_b, frame_done, err_short, err_long, err_sof} !== '0) begin
            errors++;
            $display("FAIL reset_values: got tready=%0b we=%0b addr=%0d rgb=%06h pulses=%04b, expected all zero",
                     tready, mem_we, mem_addr, {mem_r, mem_g, mem_b}, {frame_done, err_short, err_long, err_sof});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (tready !== 1'b0) begin
            errors++;
            $display("FAIL tready_before_edge: got %0b, expected 0", tready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL tready_after_release: got %0b, expected 1", tready);
        end
    endtask

    task automatic test_two_frames;
        clean_frame(8'h11);
        clean_frame(8'h22);
        drain("two_frames");
    endtask

    task automatic test_garbage;
        for (int i = 0; i < 5; i++)
            beat(1'b0, i == 2, pix(8'h33, 100 + i), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        clean_frame(8'h44);
        drain("garbage");
    endtask

    task automatic test_short_line;
        clean_line(8'h55, 0, 0, 1'b1);
        beat(1'b0, 1'b0, pix(8'h55, 4), 1'b1, AB'(4), 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b1, pix(8'h55, 5), 1'b1, AB'(5), 1'b0, 1'b1, 1'b0, 1'b0);
        clean_line(8'h55, 2, 0, 1'b0);
        clean_line(8'h55, 3, 0, 1'b0);
        drain("short_line");
    endtask

    task automatic test_long_line;
        for (int i = 0; i < 7; i++) begin
            if (i < W)
                beat(i == 0, 1'b0, pix(8'h66, i), 1'b1, AB'(i), 1'b0, 1'b0, i == W - 1, 1'b0);
            else
                beat(1'b0, i == 6, pix(8'h66, i), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int y = 1; y < LINES; y++) clean_line(8'h66, y, 0, 1'b0);
        drain("long_line");
    endtask

    task automatic test_mid_sof;
        clean_line(8'h77, 0, 0, 1'b1);
        beat(1'b0, 1'b0, pix(8'h77, 4), 1'b1, AB'(4), 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, pix(8'h77, 5), 1'b1, AB'(5), 1'b0, 1'b0, 1'b0, 1'b0);
        // SOF at pixel (2,1): written at address 0, frame restarts from x=1.
        beat(1'b1, 1'b0, pix(8'h78, 0), 1'b1, AB'(0), 1'b0, 1'b0, 1'b0, 1'b1);
        clean_line(8'h78, 0, 1, 1'b0);
        for (int y = 1; y < LINES; y++) clean_line(8'h78, y, 0, 1'b0);
        drain("mid_sof");
    endtask

    task automatic test_sof_with_tlast;
        beat(1'b1, 1'b1, pix(8'h88, 0), 1'b1, AB'(0), 1'b0, 1'b1, 1'b0, 1'b0);
        for (int y = 1; y < LINES; y++) clean_line(8'h88, y, 0, 1'b0);
        drain("sof_tlast");
    endtask

    task automatic test_enable;
        enable = 1'b0;
        for (int y = 0; y < LINES; y++)
            for (int x = 0; x < W; x++)
                beat(x == 0 && y == 0, x == W - 1, pix(8'h99, y * W + x), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("enable_off");
        // Dropping enable after SOF still completes the frame.
        enable = 1'b1;
        beat(1'b1, 1'b0, pix(8'hAA, 0), 1'b1, AB'(0), 1'b0, 1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        clean_line(8'hAA, 0, 1, 1'b0);
        for (int y = 1; y < LINES; y++) clean_line(8'hAA, y, 0, 1'b0);
        enable = 1'b1;
        drain("enable_mid");
    endtask

    task automatic test_reset_mid;
        beat(1'b1, 1'b0, pix(8'hBB, 0), 1'b1, AB'(0), 1'b0, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, pix(8'hBB, 1), 1'b1, AB'(1), 1'b0, 1'b0, 1'b0, 1'b0);
        // This beat meets reset on the same edge and must never be written.
        reset = 1'b1;
        beat(1'b0, 1'b0, pix(8'hBB, 2), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (mem_we !== 1'b0 || tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_line: got we=%0b tready=%0b, expected we=0 tready=0", mem_we, tready);
        end
        tvalid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        begin
            int budget = 10;
            while (tready !== 1'b1 && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            checks++;
            if (tready !== 1'b1) begin
                errors++;
                $display("FAIL tready_timeout: got %0b, expected 1 within 10 cycles", tready);
            end
        end
        clean_frame(8'hCC);
        drain("reset_mid");
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        tuser  = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        tvalid = 1'b0;
        test_reset();
        test_two_frames();
        test_garbage();
        test_short_line();
        test_long_line();
        test_mid_sof();
        test_sof_with_tlast();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_stream_writer.md
Name: hub75_stream_writer

Overview:
- Upstream feeder for the HUB75 panel driver's frame memory.
- Accepts an AXI4-Stream video frame (tuser = start of frame, tlast = end of line) of WIDTH x (N*HEIGHT) RGB pixels.
- Writes each pixel into the driver's memory write port (mem_we/mem_addr/mem_r/g/b) at its linear address.
- Enforces frame and line framing; drops malformed data and flags errors.

Parameters:
- N, 2, number of stacked panel halves (driver RGB lanes).
- WIDTH, 64, pixels per line.
- HEIGHT, 32, lines per panel half; total frame lines = N*HEIGHT.
- DATA_BITS, 8, bits per colour component.
- DEPTH, N*HEIGHT*WIDTH, memory words.
- ADDR_BITS, $clog2(DEPTH), memory address width.

Ports:
- reset  in  1  synchronous active-high reset
- clk  in  1  clock (driver's mem_clk domain)
- enable  in  1  accept new frames
- s_axi4s_tuser  in  1  start of frame
- s_axi4s_tlast  in  1  end of line
- s_axi4s_tdata  in  3*DATA_BITS  {r,g,b}, r in MSBs
- s_axi4s_tvalid  in  1  beat valid
- s_axi4s_tready  out  1  beat accept
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_BITS  write address
- mem_r, mem_g, mem_b  out  DATA_BITS each  pixel components
- frame_done  out  1  one-cycle pulse, complete frame written
- err_short  out  1  one-cycle pulse, tlast before WIDTH pixels
- err_long  out  1  one-cycle pulse, line exceeded WIDTH pixels
- err_sof  out  1  one-cycle pulse, tuser inside a frame

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values:
  - s_axi4s_tready=0, mem_we=0, mem_addr=0, mem_r/g/b=0.
  - All pulses 0.
  - State = WAIT_SOF, x=0, y=0.
- tready rises 1 cycle after reset release and then stays 1. The block never back-pressures; a beat is accepted when tvalid & tready.
- Output latency: the accepted beat appears on mem_we/mem_addr/mem_r/g/b on the next clock edge (1 register stage). mem_we is high for exactly one cycle per written pixel.
- Address: mem_addr = y*WIDTH + x, equal to half*HEIGHT*WIDTH + row*WIDTH + x, the driver's layout.
  - Maintain line_base (+WIDTH per line) and x counters; no multiplier.
- States:
  - WAIT_SOF:
    - Beats without tuser are discarded (no write).
    - A beat with tuser while enable=1 is written as pixel (0,0) and moves to ACTIVE.
    - A beat with tuser while enable=0 is discarded and the state stays WAIT_SOF.
  - ACTIVE, per accepted beat with x<WIDTH:
    - Write the pixel.
    - If tlast and x==WIDTH-1: go to the next line (x=0, y+1).
    - If tlast and x<WIDTH-1: err_short pulse; go to the next line, leaving remaining pixels of that line unwritten.
    - If x==WIDTH-1 and not tlast: move to DROP and pulse err_long.
    - Last line (y==N*HEIGHT-1) terminated by tlast: frame_done pulse, return to WAIT_SOF.
  - DROP:
    - Discard beats, no writes, until tlast.
    - Then go to the next line, or finish the frame (frame_done) if it was the last line.
  - tuser in ACTIVE or DROP:
    - err_sof pulse; the frame restarts.
    - That beat is written as (0,0) if enable=1; otherwise return to WAIT_SOF with no write.
    - tuser has priority over tlast and over overflow detection on the same beat.
- tuser and tlast on the same beat with WIDTH>1: treat as SOF, then the short-line rule applies (err_short, y=1).
- enable deassertion mid-frame: the current frame completes; enable is checked only at SOF.
- Reset mid-frame: immediate return to reset values; a write already registered is cancelled (mem_we=0 next cycle).
- Pulse outputs are registered and aligned with the cycle of the mem_we of the triggering beat.
- Widths: x is $clog2(WIDTH) bits, y is $clog2(N*HEIGHT) bits, line_base is ADDR_BITS bits. Counter arithmetic wraps modulo its width, but the state machine prevents overrun.

Decomposition:
- Shared package hub75_pkg:
  - state enum {WAIT_SOF, ACTIVE, DROP}.
  - Pixel struct {r,g,b} of DATA_BITS each.
  - Address-size helper constants (frame lines, DEPTH).
- Single module, no sub-module; a separate pipeline stage is not warranted for 1-cycle latency.

Test Plan:
- Two clean frames, WIDTH=4, HEIGHT=2, N=2, incrementing data -> 16 writes per frame at addr 0..15 with matching data, frame_done once per frame on the cycle of the write to addr 15, no error pulses.
- Leading garbage of 5 beats without tuser, then a clean frame -> no writes for the garbage; first write at addr 0.
- Line 1 with tlast at x=1 (WIDTH=4) -> err_short once; addrs 6,7 unwritten; next write at addr 8; frame_done still asserted.
- Line 0 of 7 beats, tlast on the 7th -> writes at addr 0..3, err_long on the 4th write cycle, beats 5-7 dropped, next line starts at addr 4.
- tuser at pixel (2,1) mid-frame -> err_sof; that beat written at addr 0 and the frame restarts.
- enable=0 at SOF -> frame ignored. Reset asserted mid-line -> tready=0 and mem_we=0 next cycle; after release a new SOF writes addr 0.
